// File: rtl/sram_pkg.sv
// Shared widths, FSM state encoding and strobe levels for the SRAM controller.
// Included by the arbiter top and its test bench.
package sram_pkg;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  // SRAM strobes are active-low, so "off" is a logic one.
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;
endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-input round-robin arbiter: combinational one-hot grant, registered
// last-granted pointer that only moves when a grant is taken.
module sram_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       ptr
);
  logic ptr_reg;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr_reg ? 2'b01 : 2'b10;
    end
  end

  // Reset value 1 means "port 1 went last", so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= 1'b1;
    end else if (accept) begin
      ptr_reg <= grant[1];
    end
  end

  assign ptr = ptr_reg;
endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin controller for a 256Kx16 asynchronous SRAM with
// fixed setup / strobe / hold sequencing and one response per access.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [1:0]        p0_be,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [1:0]        p1_be,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] ADR,
  inout  wire  [DATA_W-1:0] DAT,
  output logic              RAMCS,
  output logic              RAMOE,
  output logic              RAMWE,
  output logic              RAMLB,
  output logic              RAMUB
);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              req_we_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic [DATA_W-1:0] req_wdata_reg;
  logic              cs_reg, oe_reg, we_reg, lb_reg, ub_reg, dat_oe_reg;
  logic [1:0]        rsp_reg;
  logic [DATA_W-1:0] rdata_reg [2];

  logic [1:0] valid_vec, grant, ready_vec;
  logic       accept, owner;

  assign valid_vec = {p1_valid, p0_valid};

  // The pointer only moves on acceptance, so it names the owning port of
  // the access in flight until the next request is taken.
  sram_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid_vec),
    .accept (accept),
    .grant  (grant),
    .ptr    (owner)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign ready_vec[gi] = rst & (state_reg == IDLE) & grant[gi];
  end

  assign accept = |ready_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      req_we_reg    <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      cs_reg        <= STROBE_OFF;
      oe_reg        <= STROBE_OFF;
      we_reg        <= STROBE_OFF;
      lb_reg        <= STROBE_OFF;
      ub_reg        <= STROBE_OFF;
      dat_oe_reg    <= 1'b0;
      rsp_reg       <= '0;
      rdata_reg     <= '{default: '0};
    end else begin
      rsp_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            req_we_reg    <= grant[1] ? p1_we    : p0_we;
            req_addr_reg  <= grant[1] ? p1_addr  : p0_addr;
            req_wdata_reg <= grant[1] ? p1_wdata : p0_wdata;
            lb_reg        <= ~(grant[1] ? p1_be[0] : p0_be[0]);
            ub_reg        <= ~(grant[1] ? p1_be[1] : p0_be[1]);
            dat_oe_reg    <= grant[1] ? p1_we : p0_we;
            cs_reg        <= ~STROBE_OFF;
            state_reg     <= SETUP;
          end
        end
        SETUP: begin
          cnt_reg <= CNT_INIT;
          if (req_we_reg) begin
            we_reg <= ~STROBE_OFF;
          end else begin
            oe_reg <= ~STROBE_OFF;
          end
          state_reg <= STROBE;
        end
        STROBE: begin
          if (cnt_reg == 4'd0) begin
            we_reg         <= STROBE_OFF;
            oe_reg         <= STROBE_OFF;
            rsp_reg[owner] <= 1'b1;
            if (!req_we_reg) begin
              rdata_reg[owner] <= DAT;
            end
            state_reg <= HOLD;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        HOLD: begin
          cs_reg     <= STROBE_OFF;
          lb_reg     <= STROBE_OFF;
          ub_reg     <= STROBE_OFF;
          dat_oe_reg <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign DAT          = dat_oe_reg ? req_wdata_reg : 'z;
  assign ADR          = req_addr_reg;
  assign RAMCS        = cs_reg;
  assign RAMOE        = oe_reg;
  assign RAMWE        = we_reg;
  assign RAMLB        = lb_reg;
  assign RAMUB        = ub_reg;
  assign p0_ready     = ready_vec[0];
  assign p1_ready     = ready_vec[1];
  assign p0_rsp_valid = rsp_reg[0];
  assign p1_rsp_valid = rsp_reg[1];
  assign p0_rdata     = rdata_reg[0];
  assign p1_rdata     = rdata_reg[1];
endmodule
